// File: rtl/axi4lite_peripheral__spi_controller.sv
// AXI4-lite slave that turns each access into one mode-0 SPI frame.
// Optional: SPI_CONTROLLER_WRITE_VERIFY_EN reads back each write, bresp=match.
module axi4lite_peripheral__spi_controller #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CLOCK_DIVIDE = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic awvalid,
  output logic awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic wvalid,
  output logic wready,
  output logic bresp,
  output logic bvalid,
  input  logic bready,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic arvalid,
  output logic arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic rvalid,
  input  logic rready,
  output logic sclk,
  output logic mosi,
  input  logic miso,
  output logic cs_n
);
  localparam int N = 1 + ADDRESS_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(CLOCK_DIVIDE + 1);
  localparam int BW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE, LOW, HIGH, HOLD, GAP, RESP
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] bit_q;
  logic [N-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] rx_q, wdata_q;
  logic [ADDRESS_WIDTH-1:0] awaddr_q, araddr_q;
  logic aw_held, w_held, ar_held, is_wr_q;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic last, start_wr, start_rd, start_vfy;
  logic sample, shift, finish, wr_ok;
`ifdef SPI_CONTROLLER_WRITE_VERIFY_EN
  logic vfy_q;
`endif

  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign b_hs = bvalid & bready;
  assign r_hs = rvalid & rready;
  assign last = (cnt_q == CW'(CLOCK_DIVIDE - 1));

`ifdef SPI_CONTROLLER_WRITE_VERIFY_EN
  assign wr_ok = (rx_q == wdata_q);
`else
  assign wr_ok = 1'b1;
`endif

  // Frame sequencer: next state and per-cycle strobes.
  always_comb begin
    state_d = state_q;
    start_wr = 1'b0;
    start_rd = 1'b0;
    start_vfy = 1'b0;
    sample = 1'b0;
    shift = 1'b0;
    finish = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bvalid && !rvalid) begin
          if (aw_held && w_held) begin
            start_wr = 1'b1;
            state_d = LOW;
          end else if (ar_held) begin
            start_rd = 1'b1;
            state_d = LOW;
          end
        end
      end
      LOW: if (last) state_d = HIGH;
      HIGH: begin
        sample = (cnt_q == '0);
        if (last) begin
          if (bit_q == BW'(N - 1)) begin
            state_d = HOLD;
          end else begin
            shift = 1'b1;
            state_d = LOW;
          end
        end
      end
      HOLD: if (last) state_d = GAP;
      GAP: begin
        if (last) begin
`ifdef SPI_CONTROLLER_WRITE_VERIFY_EN
          if (is_wr_q && !vfy_q) begin
            start_vfy = 1'b1;
            state_d = LOW;
          end else begin
            finish = 1'b1;
            state_d = RESP;
          end
`else
          finish = 1'b1;
          state_d = RESP;
`endif
        end
      end
      RESP: if (b_hs || r_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift register load and advance.
  always_comb begin
    shreg_d = shreg_q;
    if (start_wr)
      shreg_d = {1'b1, awaddr_q, wdata_q};
    else if (start_rd)
      shreg_d = {1'b0, araddr_q, {DATA_WIDTH{1'b0}}};
    else if (start_vfy)
      shreg_d = {1'b0, awaddr_q, {DATA_WIDTH{1'b0}}};
    else if (shift)
      shreg_d = {shreg_q[N-2:0], 1'b0};
  end

  // State register with per-state cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end
  end

  // SPI datapath and registered pin drivers.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q <= '0;
      bit_q <= '0;
      rx_q <= '0;
      is_wr_q <= 1'b0;
      sclk <= 1'b0;
      cs_n <= 1'b1;
      mosi <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      if (start_wr || start_rd || start_vfy) bit_q <= '0;
      else if (shift) bit_q <= bit_q + 1'b1;
      if (start_wr) is_wr_q <= 1'b1;
      else if (start_rd) is_wr_q <= 1'b0;
      if (sample) rx_q <= {rx_q[DATA_WIDTH-2:0], miso};
      sclk <= (state_d == HIGH);
      cs_n <= !(state_d == LOW || state_d == HIGH ||
                state_d == HOLD);
      mosi <= (state_d == LOW || state_d == HIGH) &&
              shreg_d[N-1];
    end
  end

`ifdef SPI_CONTROLLER_WRITE_VERIFY_EN
  // Marks the read-back frame that follows a write.
  always_ff @(posedge clock) begin
    if (reset) vfy_q <= 1'b0;
    else if (start_wr || start_rd) vfy_q <= 1'b0;
    else if (start_vfy) vfy_q <= 1'b1;
  end
`endif

  // AXI channel capture, readies and responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      awaddr_q <= '0;
      wdata_q <= '0;
      araddr_q <= '0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      ar_held <= 1'b0;
      awready <= 1'b0;
      wready <= 1'b0;
      arready <= 1'b0;
      bvalid <= 1'b0;
      bresp <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
    end else begin
      if (aw_hs) awaddr_q <= awaddr;
      if (w_hs) wdata_q <= wdata;
      if (ar_hs) araddr_q <= araddr;
      aw_held <= (aw_held | aw_hs) & ~b_hs;
      w_held <= (w_held | w_hs) & ~b_hs;
      ar_held <= (ar_held | ar_hs) & ~r_hs;
      awready <= ~((aw_held | aw_hs) & ~b_hs);
      wready <= ~((w_held | w_hs) & ~b_hs);
      arready <= ~((ar_held | ar_hs) & ~r_hs);
      if (finish && is_wr_q) begin
        bvalid <= 1'b1;
        bresp <= wr_ok;
      end else if (b_hs) begin
        bvalid <= 1'b0;
        bresp <= 1'b0;
      end
      if (finish && !is_wr_q) begin
        rvalid <= 1'b1;
        rdata <= rx_q;
      end else if (r_hs) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_peripheral__spi_controller.sv
// Directed bench with a memory-backed SPI peripheral model and frame monitor.
// Define SPI_CONTROLLER_WRITE_VERIFY_EN to also cover the read-back path.
module tb_axi4lite_peripheral__spi_controller;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int CD = 2;
  localparam int N = 1 + AW + DW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] awaddr = '0;
  logic awvalid = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic wvalid = 1'b0;
  logic bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic arvalid = 1'b0;
  logic rready = 1'b0;
  logic miso = 1'b0;
  logic awready, wready, bresp, bvalid;
  logic arready, rvalid, sclk, mosi, cs_n;
  logic [DW-1:0] rdata;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  axi4lite_peripheral__spi_controller dut (
    .clock(clock), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];
  logic [N-1:0] exp_q [$];
  logic exp_b [$];
  logic [DW-1:0] exp_r [$];
  logic corrupt = 1'b0;

  logic in_frame = 1'b0;
  logic fr_abort = 1'b0;
  logic fr_rw = 1'b0;
  logic [AW-1:0] fr_addr = '0;
  logic [N-1:0] fr_bits = '0;
  int fr_rises = 0;
  int fr_low = 0;
  logic [DW-1:0] tx = '0;
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;
  logic [N-1:0] wr_last = '0;
  logic [N-1:0] rd_last = '0;
  int wr_low = 0;
  int wr_rises = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // SPI peripheral model plus per-cycle output comparison.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      exp_b.delete();
      exp_r.delete();
      if (in_frame) fr_abort = 1'b1;
    end
    if (!cs_n && prev_cs) begin
      in_frame = 1'b1;
      fr_abort = reset;
      fr_rises = 0;
      fr_low = 0;
      fr_bits = '0;
      fr_rw = 1'b0;
      fr_addr = '0;
    end
    if (in_frame && !cs_n) begin
      fr_low++;
      if (sclk && !prev_sclk) begin
        fr_bits = {fr_bits[N-2:0], mosi};
        fr_rises++;
        if (fr_rises == 1) fr_rw = mosi;
        else if (fr_rises <= 1 + AW)
          fr_addr = {fr_addr[AW-2:0], mosi};
      end
      if (!sclk && prev_sclk && !fr_rw &&
          fr_rises >= 1 + AW && fr_rises < N) begin
        if (fr_rises == 1 + AW)
          tx = mem[fr_addr] ^ {{(DW-1){1'b0}}, corrupt};
        miso = tx[DW-1-(fr_rises-1-AW)];
      end
    end
    if (in_frame && cs_n && !prev_cs) begin
      in_frame = 1'b0;
      miso = 1'b0;
      if (!fr_abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected frame", fr_rises, 0);
        end else begin
          chk("frame bits", fr_bits, exp_q[0]);
          exp_q.delete(0);
          chk("sclk rises", fr_rises, N);
          chk("cs_n low cycles", fr_low, (2*N+1)*CD);
        end
        if (fr_rw) begin
          mem[fr_addr] = fr_bits[DW-1:0];
          wr_last = fr_bits;
          wr_low = fr_low;
          wr_rises = fr_rises;
        end else begin
          rd_last = fr_bits;
        end
      end
    end
    if (!reset) begin
      if (cs_n) chk("sclk idle", sclk, 0);
      if (bvalid) begin
        chk("cs_n idle with bvalid", cs_n, 1);
        if (exp_b.size() == 0) begin
          chk("unexpected bvalid", bvalid, 0);
        end else begin
          chk("bresp", bresp, exp_b[0]);
          if (bready) exp_b.delete(0);
        end
      end
      if (rvalid) begin
        chk("cs_n idle with rvalid", cs_n, 1);
        if (exp_r.size() == 0) begin
          chk("unexpected rvalid", rvalid, 0);
        end else begin
          chk("rdata", rdata, exp_r[0]);
          if (rready) exp_r.delete(0);
        end
      end
    end
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    ref_mem[a] = d;
    exp_q.push_back({1'b1, a, d});
`ifdef SPI_CONTROLLER_WRITE_VERIFY_EN
    exp_q.push_back({1'b0, a, {DW{1'b0}}});
    exp_b.push_back(!corrupt);
`else
    exp_b.push_back(1'b1);
`endif
  endtask

  task automatic expect_rd(input logic [AW-1:0] a);
    exp_q.push_back({1'b0, a, {DW{1'b0}}});
    exp_r.push_back(ref_mem[a]);
  endtask

  task automatic send_aw(input logic [AW-1:0] a);
    int n = 0;
    awaddr = a;
    awvalid = 1'b1;
    while (!awready && n < 2000) begin step(); n++; end
    chk("awready seen", awready, 1);
    step();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d);
    int n = 0;
    wdata = d;
    wvalid = 1'b1;
    while (!wready && n < 2000) begin step(); n++; end
    chk("wready seen", wready, 1);
    step();
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    int n = 0;
    araddr = a;
    arvalid = 1'b1;
    while (!arready && n < 2000) begin step(); n++; end
    chk("arready seen", arready, 1);
    step();
    arvalid = 1'b0;
  endtask

  task automatic wait_b(input int hold, input logic e);
    int n = 0;
    while (!bvalid && n < 2000) begin step(); n++; end
    chk("bvalid seen", bvalid, 1);
    chk("bresp literal", bresp, e);
    repeat (hold) begin
      step();
      chk("bvalid held", bvalid, 1);
      chk("awready low in b", awready, 0);
      chk("no frame in b", cs_n, 1);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bvalid cleared", bvalid, 0);
    chk("awready back", awready, 1);
    chk("wready back", wready, 1);
  endtask

  task automatic wait_r(input int hold, input logic [DW-1:0] e);
    int n = 0;
    while (!rvalid && n < 2000) begin step(); n++; end
    chk("rvalid seen", rvalid, 1);
    chk("rdata literal", rdata, e);
    repeat (hold) begin
      step();
      chk("rvalid held", rvalid, 1);
      chk("rdata held", rdata, e);
      chk("arready low in r", arready, 0);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rvalid cleared", rvalid, 0);
    chk("arready back", arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[12] = 32'h00aa00aa;
    ref_mem[12] = 32'h00aa00aa;

    repeat (3) step();
    chk("rst awready", awready, 0);
    chk("rst wready", wready, 0);
    chk("rst arready", arready, 0);
    chk("rst bvalid", bvalid, 0);
    chk("rst bresp", bresp, 0);
    chk("rst rvalid", rvalid, 0);
    chk("rst rdata", rdata, 0);
    chk("rst sclk", sclk, 0);
    chk("rst mosi", mosi, 0);
    chk("rst cs_n", cs_n, 1);
    reset = 1'b0;
    step();
    chk("awready up", awready, 1);
    chk("wready up", wready, 1);
    chk("arready up", arready, 1);

    expect_wr(4'h2, 32'h12345678);
    fork
      send_aw(4'h2);
      send_w(32'h12345678);
    join
    wait_b(0, 1'b1);
    chk("t1 frame", wr_last, 37'h1212345678);
    chk("t1 rises", wr_rises, 37);
    chk("t1 cs_n low", wr_low, 150);

    expect_rd(4'hc);
    send_ar(4'hc);
    wait_r(3, 32'h00aa00aa);
    chk("t2 header", rd_last[N-1:N-5], 5'b01100);

    expect_wr(4'h3, 32'habcdef01);
    expect_rd(4'h3);
    fork
      send_aw(4'h3);
      send_w(32'habcdef01);
      send_ar(4'h3);
    join
    wait_b(0, 1'b1);
    wait_r(0, 32'habcdef01);

    expect_wr(4'h5, 32'hdeadbeef);
    fork
      send_w(32'hdeadbeef);
      begin
        repeat (3) begin
          step();
          chk("no frame before aw", cs_n, 1);
        end
        send_aw(4'h5);
      end
    join
    wait_b(0, 1'b1);
    chk("t4 frame", wr_last, 37'h15deadbeef);

    expect_wr(4'h6, 32'h0f0f0f0f);
    expect_rd(4'h6);
    fork
      send_aw(4'h6);
      send_w(32'h0f0f0f0f);
    join
    send_ar(4'h6);
    wait_b(20, 1'b1);
    wait_r(0, 32'h0f0f0f0f);

    expect_wr(4'h7, 32'h13572468);
    fork
      send_aw(4'h7);
      send_w(32'h13572468);
    join
    n = 0;
    while (!(in_frame && fr_rises >= 10) && n < 2000) begin
      step();
      n++;
    end
    chk("t6 tenth rise", fr_rises, 10);
    reset = 1'b1;
    step();
    chk("t6 cs_n", cs_n, 1);
    chk("t6 sclk", sclk, 0);
    chk("t6 bvalid", bvalid, 0);
    chk("t6 mosi", mosi, 0);
    chk("t6 awready", awready, 0);
    reset = 1'b0;
    step();
    chk("t6 awready up", awready, 1);
    expect_wr(4'hd, 32'h55550000);
    fork
      send_aw(4'hd);
      send_w(32'h55550000);
    join
    wait_b(0, 1'b1);
    chk("t6 frame", wr_last, 37'h1d55550000);
    expect_rd(4'hd);
    send_ar(4'hd);
    wait_r(0, 32'h55550000);

`ifdef SPI_CONTROLLER_WRITE_VERIFY_EN
    corrupt = 1'b1;
    expect_wr(4'h9, 32'h000000ff);
    fork
      send_aw(4'h9);
      send_w(32'h000000ff);
    join
    wait_b(0, 1'b0);
    corrupt = 1'b0;
`endif

    repeat (5) step();
    chk("queues drained", exp_q.size() + exp_b.size() +
        exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4lite_peripheral__spi_controller.md
Name: axi4lite_peripheral__spi_controller

Overview:
- AXI4-lite peripheral that acts as an SPI controller toward an external SPI peripheral. It is the other end of the SPI link that feeds our spi_peripheral__axi4lite_controller.
- Each AXI write becomes one SPI write frame; each AXI read becomes one SPI read frame. Read data returns on the R channel.
- Lets one FPGA reach a remote board's AXI register space over four wires.

Parameters:
- ADDRESS_WIDTH, 4, AXI word address width; also the SPI address field width.
- DATA_WIDTH, 32, data word width.
- CLOCK_DIVIDE, 2, SPI half-period in clock cycles; must be >=1.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- awaddr  input  ADDRESS_WIDTH  write address
- awvalid  input  1  AW valid
- awready  output  1  AW ready
- wdata  input  DATA_WIDTH  write data
- wvalid  input  1  W valid
- wready  output  1  W ready
- bresp  output  1  write status; 1 = success
- bvalid  output  1  B valid
- bready  input  1  B ready
- araddr  input  ADDRESS_WIDTH  read address
- arvalid  input  1  AR valid
- arready  output  1  AR ready
- rdata  output  DATA_WIDTH  read data
- rvalid  output  1  R valid
- rready  input  1  R ready
- sclk  output  1  SPI clock, mode 0 (idles low)
- mosi  output  1  controller-out serial data
- miso  input  1  peripheral-out serial data
- cs_n  output  1  active-low chip select

Behaviour:
- Reset values: awready=wready=arready=0, bvalid=0, bresp=0, rvalid=0, rdata=0, sclk=0, mosi=0, cs_n=1. The three readies rise 1 cycle after reset deasserts.
- AXI write capture:
  - AW and W are captured independently, in either order; a captured channel's ready drops the cycle after its handshake.
  - A write is pending once both are held.
- AXI read capture: AR is captured the same way; arready drops after its handshake.
- Arbitration: if a write and a read are pending in the same cycle, the write frame goes first.
- Frame format, N = 1+ADDRESS_WIDTH+DATA_WIDTH bits, MSB first:
  - Bit 1: R/W bit, 1 = write, 0 = read.
  - Next ADDRESS_WIDTH bits: address.
  - Last DATA_WIDTH bits, write frame: mosi carries wdata.
  - Last DATA_WIDTH bits, read frame: mosi=0; miso is shifted in.
- FSM: IDLE -> LOW -> HIGH -> (LOW | HOLD) -> GAP -> RESP -> IDLE.
  - LOW: cs_n=0, sclk=0, mosi holds the current bit, CLOCK_DIVIDE cycles.
  - HIGH: sclk=1 for CLOCK_DIVIDE cycles; miso sampled on the cycle sclk rises.
  - After bit N's HIGH: HOLD, sclk=0, cs_n=0, CLOCK_DIVIDE cycles.
  - GAP: cs_n=1 for CLOCK_DIVIDE cycles.
  - RESP: the frame's response is presented.
- Frame timing: exactly N sclk rising edges per frame; cs_n low for (2N+1)*CLOCK_DIVIDE cycles.
- Write response: bvalid=1, bresp=1, held until bready. The cycle after the B handshake, awready and wready return to 1.
- Read response: rvalid=1, rdata=shifted word, both held stable until rready. The cycle after the R handshake, arready returns to 1.
- Ordering: at most one frame in flight. A pending request of the other type waits in IDLE. A new frame never starts while this block holds bvalid or rvalid high.
- Reset mid-frame: cs_n=1 and sclk=0 on the next edge. Captured requests and responses are discarded.

Optional Feature:
- Macro: SPI_CONTROLLER_WRITE_VERIFY_EN.
- Defined:
  - After each write frame plus GAP, issue a read frame to the same address.
  - bresp=1 only if the read-back equals wdata, else bresp=0.
  - bvalid is delayed by one extra frame plus GAP.
- Undefined: bresp is always 1 and no read-back frame is issued.

Test Plan:
- Write 0x2 <- 0x12345678 (CLOCK_DIVIDE=2, N=37) -> mosi = 1,0010, then 0x12345678 MSB first; 37 sclk rises; cs_n low 150 cycles; then bvalid=1, bresp=1.
- Read 0xC with the SPI model driving 0x00aa00aa -> mosi first 5 bits = 0,1100; rdata=0x00aa00aa, rvalid held until rready.
- AW, W and AR all valid in the same cycle (write 0x3 <- 0xabcdef01, read 0x3) -> write frame first, GAP, then read frame; rdata=0xabcdef01 from the loopback model.
- W valid 3 cycles before AW -> no frame until AW is captured; then one normal write frame.
- bready held low for 20 cycles after bvalid -> bvalid stays 1, awready stays 0, no new frame starts; B handshake completes when bready rises.
- Reset asserted after the 10th sclk rise -> next edge cs_n=1, sclk=0, bvalid=0. A following write of 0xd <- 0x55550000 completes normally.
- With SPI_CONTROLLER_WRITE_VERIFY_EN defined, SPI model corrupts bit 0 -> bresp=0.
